// File: rtl/rc4_crack_pkg.sv
// rtl/rc4_crack_pkg.sv - shared types and defaults for the RC4 key-search dispatcher
package rc4_crack_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } dispatch_state_t;

  localparam int KEY_W_DEFAULT = 24;

endpackage

// File: rtl/rc4_crack_dispatcher_if.sv
// rtl/rc4_crack_dispatcher_if.sv - dispatcher <-> crack-core array bus
interface rc4_crack_dispatcher_if #(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = 24
);
  logic [NUM_CORES-1:0][KEY_W-1:0] core_key;
  logic [NUM_CORES-1:0]            core_start;
  logic [NUM_CORES-1:0]            core_done;
  logic [NUM_CORES-1:0]            core_valid;

  modport master (
    output core_key,
    output core_start,
    input  core_done,
    input  core_valid
  );

  modport slave (
    input  core_key,
    input  core_start,
    output core_done,
    output core_valid
  );
endinterface

// File: rtl/rc4_crack_slot.sv
// rtl/rc4_crack_slot.sv - per-core key register, start pulse and in-flight flag
module rc4_crack_slot
  import rc4_crack_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             retire,
  input  logic [KEY_W-1:0] load_key,
  output logic [KEY_W-1:0] core_key,
  output logic             core_start,
  output logic             inflight
);

  // A load on the same cycle as a global clear wins: the restart dispatch reuses this slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_key   <= '0;
      core_start <= 1'b0;
      inflight   <= 1'b0;
    end else begin
      core_start <= load;
      if (load) begin
        core_key <= load_key;
        inflight <= 1'b1;
      end else if (clear || retire) begin
        inflight <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rc4_crack_dispatcher.sv
// rtl/rc4_crack_dispatcher.sv - round-robin RC4 key-range dispatcher over NUM_CORES crack cores
// keys_tried counter is built only when RC4_CRACK_PROGRESS_EN is defined.
module rc4_crack_dispatcher
  import rc4_crack_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int CORE_ID_W = 2,
  parameter int KEY_W     = KEY_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [KEY_W-1:0]       key_lo,
  input  logic [KEY_W-1:0]       key_hi,
  rc4_crack_dispatcher_if.master cores,
  output logic                   busy,
  output logic                   finish,
  output logic                   found,
  output logic [KEY_W-1:0]       secret_key,
  output logic [CORE_ID_W-1:0]   found_core_id,
  output logic [KEY_W:0]         keys_tried
);

  dispatch_state_t state;
  logic [CORE_ID_W-1:0] ptr;
  logic [KEY_W-1:0]     next_key;
  logic [KEY_W-1:0]     hi_r;

  logic [NUM_CORES-1:0][KEY_W-1:0] key_q;
  logic [NUM_CORES-1:0]            start_q;
  logic [NUM_CORES-1:0]            inflight_vec;
  logic [NUM_CORES-1:0]            retire_mask;
  logic [NUM_CORES-1:0]            remaining;

  logic                 sel_inflight, sampled, hit;
  logic                 abort_take, start_take, clear_all;
  logic                 dispatch_en, retire_en;
  logic [CORE_ID_W-1:0] dispatch_idx;
  logic [KEY_W-1:0]     dispatch_key;

  function automatic logic [CORE_ID_W-1:0] wrap_inc(input logic [CORE_ID_W-1:0] p);
    return (p == CORE_ID_W'(NUM_CORES - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cores.core_key   = key_q;
  assign cores.core_start = start_q;

  // A core still showing its start pulse has not yet dropped core_done, so it is never sampled then.
  always_comb begin
    sel_inflight = inflight_vec[ptr];
    sampled      = sel_inflight && !start_q[ptr] && cores.core_done[ptr];
    hit          = sampled && cores.core_valid[ptr];
    abort_take   = abort && (state != S_IDLE);
    start_take   = start && !abort_take && ((state == S_IDLE) || (state == S_DONE));
    clear_all    = abort_take || start_take;
    dispatch_en  = 1'b0;
    dispatch_idx = ptr;
    dispatch_key = next_key;
    retire_en    = 1'b0;
    if (start_take) begin
      dispatch_en  = (key_lo <= key_hi);
      dispatch_idx = '0;
      dispatch_key = key_lo;
    end else if (!abort_take && (state == S_DISPATCH) && !hit && (!sel_inflight || sampled)) begin
      dispatch_en = 1'b1;
    end
    if (!abort_take && (state == S_DRAIN) && sampled) begin
      retire_en = 1'b1;
    end
    retire_mask      = '0;
    retire_mask[ptr] = retire_en;
    remaining        = inflight_vec & ~retire_mask;
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
    rc4_crack_slot #(.KEY_W(KEY_W)) u_slot (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear_all),
      .load       (dispatch_en && (dispatch_idx == CORE_ID_W'(i))),
      .retire     (retire_mask[i]),
      .load_key   (dispatch_key),
      .core_key   (key_q[i]),
      .core_start (start_q[i]),
      .inflight   (inflight_vec[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      ptr           <= '0;
      next_key      <= '0;
      hi_r          <= '0;
      busy          <= 1'b0;
      finish        <= 1'b0;
      found         <= 1'b0;
      secret_key    <= '0;
      found_core_id <= '0;
    end else if (abort_take) begin
      state  <= S_DONE;
      busy   <= 1'b0;
      finish <= 1'b1;
      found  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_take) begin
            found <= 1'b0;
            hi_r  <= key_hi;
            // The first key goes to core 0 on the start edge itself.
            if (dispatch_en) begin
              state      <= (key_lo == key_hi) ? S_DRAIN : S_DISPATCH;
              next_key   <= key_lo + KEY_W'(1);
              ptr        <= wrap_inc('0);
              secret_key <= key_lo;
              busy       <= 1'b1;
              finish     <= 1'b0;
            end else begin
              state    <= S_DONE;
              next_key <= key_lo;
              ptr      <= '0;
              busy     <= 1'b0;
              finish   <= 1'b1;
            end
          end
        end
        S_DISPATCH, S_DRAIN: begin
          ptr <= wrap_inc(ptr);
          if (hit) begin
            state         <= S_DONE;
            busy          <= 1'b0;
            finish        <= 1'b1;
            found         <= 1'b1;
            secret_key    <= key_q[ptr];
            found_core_id <= ptr;
          end else if (dispatch_en) begin
            secret_key <= next_key;
            // Compare against the end of range instead of relying on wrap, so all-ones is a legal key_hi.
            if (next_key == hi_r) begin
              state <= S_DRAIN;
            end else begin
              next_key <= next_key + KEY_W'(1);
            end
          end else if ((state == S_DRAIN) && (remaining == '0)) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            finish     <= 1'b1;
            secret_key <= hi_r;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RC4_CRACK_PROGRESS_EN
  logic [KEY_W:0] tried_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tried_q <= '0;
    end else if (start_take) begin
      tried_q <= {{KEY_W{1'b0}}, dispatch_en};
    end else if (dispatch_en) begin
      tried_q <= tried_q + (KEY_W + 1)'(1);
    end
  end

  assign keys_tried = tried_q;
`else
  assign keys_tried = '0;
`endif

endmodule

// File: tb/tb_rc4_crack_dispatcher.sv
// tb/tb_rc4_crack_dispatcher.sv - directed-vector bench for rc4_crack_dispatcher (4-core and 1-core builds)
module tb_rc4_crack_dispatcher;
  localparam int KW   = 24;
  localparam int LAT  = 20;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0, abort = 1'b0;
  logic [KW-1:0] key_lo = '0, key_hi = '0;
  logic          busy, finish, found;
  logic [KW-1:0] secret_key;
  logic [1:0]    found_core_id;
  logic [KW:0]   keys_tried;

  logic          start1 = 1'b0, abort1 = 1'b0;
  logic [KW-1:0] key_lo1 = '0, key_hi1 = '0;
  logic          busy1, finish1, found1;
  logic [KW-1:0] secret_key1;
  logic [0:0]    found_core_id1;
  logic [KW:0]   keys_tried1;

  rc4_crack_dispatcher_if #(.NUM_CORES(4), .KEY_W(KW)) cif ();
  rc4_crack_dispatcher_if #(.NUM_CORES(1), .KEY_W(KW)) cif1 ();

  rc4_crack_dispatcher #(.NUM_CORES(4), .CORE_ID_W(2), .KEY_W(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .key_lo(key_lo), .key_hi(key_hi),
    .cores(cif.master), .busy(busy), .finish(finish), .found(found), .secret_key(secret_key),
    .found_core_id(found_core_id), .keys_tried(keys_tried)
  );

  rc4_crack_dispatcher #(.NUM_CORES(1), .CORE_ID_W(1), .KEY_W(KW)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1), .key_lo(key_lo1), .key_hi(key_hi1),
    .cores(cif1.master), .busy(busy1), .finish(finish1), .found(found1), .secret_key(secret_key1),
    .found_core_id(found_core_id1), .keys_tried(keys_tried1)
  );

  // Behavioural crack cores: busy for a fixed latency after each start pulse.
  logic [KW-1:0] target = '0, target1 = '1;
  logic [3:0]    vmask = '0;
  logic [KW-1:0] mkey [4];
  int            mcnt [4];
  logic [KW-1:0] mkey1;
  int            mcnt1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cif.core_done  <= '1;
      cif.core_valid <= '0;
      cif1.core_done  <= '1;
      cif1.core_valid <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cif.core_start[i]) begin
          mkey[i]           <= cif.core_key[i];
          mcnt[i]           <= LAT - 1;
          cif.core_done[i]  <= 1'b0;
          cif.core_valid[i] <= 1'b0;
        end else if (!cif.core_done[i]) begin
          if (mcnt[i] == 0) begin
            cif.core_done[i]  <= 1'b1;
            cif.core_valid[i] <= (mkey[i] == target) || vmask[i];
          end else begin
            mcnt[i] <= mcnt[i] - 1;
          end
        end
      end
      if (cif1.core_start[0]) begin
        mkey1              <= cif1.core_key[0];
        mcnt1              <= LAT1 - 1;
        cif1.core_done[0]  <= 1'b0;
        cif1.core_valid[0] <= 1'b0;
      end else if (!cif1.core_done[0]) begin
        if (mcnt1 == 0) begin
          cif1.core_done[0]  <= 1'b1;
          cif1.core_valid[0] <= (mkey1 == target1);
        end else begin
          mcnt1 <= mcnt1 - 1;
        end
      end
    end
  end

  int pulses = 0, pulses1 = 0, cyc = 0, last1 = -100, gap_bad = 0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 4; i++) if (cif.core_start[i]) pulses = pulses + 1;
    if (cif1.core_start[0]) begin
      if (cyc - last1 < 2) gap_bad = gap_bad + 1;
      last1   = cyc;
      pulses1 = pulses1 + 1;
    end
  end

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int exp_tried(input int p);
`ifdef RC4_CRACK_PROGRESS_EN
    return p;
`else
    return 0;
`endif
  endfunction

  task automatic wait_finish(input bit which, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ((which ? finish1 : finish) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    string         name;
    logic [KW-1:0] lo, hi, tgt;
    logic [3:0]    mask;
    logic          exp_found;
    logic          chk_key;
    logic [KW-1:0] exp_key;
    logic [1:0]    exp_id;
    int            exp_pulses;
    logic          exact;
  } vec_t;

  vec_t vt [6];
  bit   ok;

  initial begin
    vt[0] = '{"hit17",   24'h000010, 24'h00001F, 24'h000017, 4'b0000, 1'b1, 1'b1, 24'h000017, 2'd3, 16, 1'b0};
    vt[1] = '{"inverted",24'h000005, 24'h000004, 24'h000005, 4'b0000, 1'b0, 1'b0, 24'h000000, 2'd0, 0,  1'b1};
    vt[2] = '{"top",     24'hFFFFF0, 24'hFFFFFF, 24'h000000, 4'b0000, 1'b0, 1'b1, 24'hFFFFFF, 2'd0, 16, 1'b1};
    vt[3] = '{"dual",    24'h000100, 24'h00013F, 24'hFFFFFF, 4'b0110, 1'b1, 1'b1, 24'h000101, 2'd1, 64, 1'b0};
    vt[4] = '{"short3",  24'h000020, 24'h000022, 24'h000022, 4'b0000, 1'b1, 1'b1, 24'h000022, 2'd2, 3,  1'b1};
    vt[5] = '{"single",  24'h000030, 24'h000030, 24'h000030, 4'b0000, 1'b1, 1'b1, 24'h000030, 2'd0, 1,  1'b1};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
    check("rst_found", found, 0);
    check("rst_secret", secret_key, 0);
    check("rst_id", found_core_id, 0);
    check("rst_tried", keys_tried, 0);
    check("rst_core_start", cif.core_start, 0);
    check("rst_core_key_zero", (cif.core_key == '0), 1);
    reset = 1'b0;

    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      target = vt[n].tgt;
      vmask  = vt[n].mask;
      pulses = 0;
      key_lo = vt[n].lo;
      key_hi = vt[n].hi;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (vt[n].lo > vt[n].hi) begin
        check({vt[n].name, "_finish_1cyc"}, finish, 1);
        check({vt[n].name, "_busy_1cyc"}, busy, 0);
      end else begin
        check({vt[n].name, "_first_start"}, cif.core_start[0], 1);
        check({vt[n].name, "_first_key"}, cif.core_key[0], vt[n].lo);
      end
      wait_finish(1'b0, ok);
      check({vt[n].name, "_no_timeout"}, ok, 1);
      check({vt[n].name, "_found"}, found, vt[n].exp_found);
      check({vt[n].name, "_busy"}, busy, 0);
      if (vt[n].chk_key) check({vt[n].name, "_key"}, secret_key, vt[n].exp_key);
      if (vt[n].exp_found) check({vt[n].name, "_id"}, found_core_id, vt[n].exp_id);
      if (vt[n].exact) check({vt[n].name, "_pulses"}, pulses, vt[n].exp_pulses);
      else check({vt[n].name, "_pulses_le"}, (pulses <= vt[n].exp_pulses), 1);
      check({vt[n].name, "_tried"}, keys_tried, exp_tried(pulses));
    end

    // Abort mid-search, then a clean restart from a new range.
    @(negedge clk);
    target = '1; vmask = '0;
    key_lo = 24'h000200; key_hi = 24'h0002FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_finish", finish, 1);
    check("abort_found", found, 0);
    check("abort_busy", busy, 0);
    target = 24'h000401;
    key_lo = 24'h000400; key_hi = 24'h000401; start = 1'b1; pulses = 0;
    @(negedge clk);
    start = 1'b0;
    check("restart_pulse", cif.core_start[0], 1);
    check("restart_key", cif.core_key[0], 24'h000400);
    check("restart_finish_clr", finish, 0);
    wait_finish(1'b0, ok);
    check("restart_no_timeout", ok, 1);
    check("restart_found", found, 1);
    check("restart_key_won", secret_key, 24'h000401);
    check("restart_id", found_core_id, 1);

    // Asynchronous reset in the middle of a search.
    @(negedge clk);
    target = '1;
    key_lo = 24'h000000; key_hi = 24'h0000FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_core_start", cif.core_start, 0);
    check("midrst_key_zero", (cif.core_key == '0), 1);
    check("midrst_secret", secret_key, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single-core build: start pulses must be spaced by at least two cycles.
    @(negedge clk);
    pulses1 = 0; gap_bad = 0;
    key_lo1 = 24'h000000; key_hi1 = 24'h000007; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_finish(1'b1, ok);
    repeat (2) @(negedge clk);
    check("one_no_timeout", ok, 1);
    check("one_found", found1, 0);
    check("one_key", secret_key1, 24'h000007);
    check("one_pulses", pulses1, 8);
    check("one_gap", gap_bad, 0);
    check("one_tried", keys_tried1, exp_tried(8));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rc4_crack_dispatcher.md
# rc4_crack_dispatcher

Parametrised multi-core key-search dispatcher for the RC4 cracker. It hands consecutive candidate keys from a programmable range `[key_lo, key_hi]` to `NUM_CORES` external crack cores, collects pass/fail results and reports the first valid key. It supports start/abort control and drains in-flight cores when the range is exhausted. It sits between the top-level control/display logic and the array of crack cores.

## Interface
- `NUM_CORES`, default 4: number of attached crack cores, ≥1.
- `CORE_ID_W`, default 2: width of core index, ≥ max(1, $clog2(NUM_CORES)).
- `KEY_W`, default 24: candidate key width.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; latches `key_lo`/`key_hi` and begins search. Honoured only in IDLE or DONE.
- `abort`  in  1  level; terminates the search from any non-IDLE state.
- `key_lo`, `key_hi`  in  KEY_W each  inclusive search range.
- `core_key`  out  NUM_CORES×KEY_W  key presented to each core; stable while the core is in flight.
- `core_start`  out  NUM_CORES  one-cycle start/reset pulse per core.
- `core_done`  in  NUM_CORES  core idle/finished.
- `core_valid`  in  NUM_CORES  core result is valid; meaningful only with `core_done`.
- `busy`  out  1  search in progress (DISPATCH or DRAIN).
- `finish`  out  1  search ended; held until next `start` or `reset`.
- `found`  out  1  valid key located; qualified by `finish`.
- `secret_key`  out  KEY_W  winning key when `found`, else last key dispatched.
- `found_core_id`  out  CORE_ID_W  core that produced the winning key.
- `keys_tried`  out  KEY_W+1  count of keys dispatched.

## Operation
- States: IDLE, DISPATCH, DRAIN, DONE.
- Per-core `inflight` bit. A round-robin scan pointer `ptr` visits one core per cycle and wraps from NUM_CORES-1 to 0.
- IDLE/DONE + `start`:
  - latch range; `next_key`←`key_lo`; clear `inflight`, `keys_tried`, `found`, `finish`; `ptr`←0.
  - If `key_lo > key_hi`, go to DONE with `found`=0.
  - Otherwise go to DISPATCH.
- DISPATCH, at core `ptr`:
  - If `inflight && core_done && core_valid`: `found`=1, `secret_key`=`core_key[ptr]`, `found_core_id`=`ptr`; go to DONE.
  - Else if `!inflight || core_done`: drive `core_key[ptr]`←`next_key`, pulse `core_start[ptr]`, set `inflight`, increment `keys_tried`.
    - If `next_key == key_hi`, set `exhausted` and go to DRAIN. The range end is detected by compare, never by overflow, so `key_hi` = all-ones is legal.
    - Otherwise `next_key++`.
  - Else (core busy): no action.
  - `ptr` advances every cycle.
- DRAIN:
  - Keep scanning. A visited in-flight core with `core_done` clears `inflight`.
  - If that core also has `core_valid`, report found exactly as in DISPATCH.
  - When no core is in flight: DONE with `found`=0, `secret_key`=`key_hi`.
- Multiple valid cores: the first one reached in scan order wins.
- `abort` (non-IDLE): go to DONE next cycle with `found`=0 and `inflight` cleared. `abort` has priority over a simultaneous found.
- DONE ignores `core_*` inputs.

## Timing
- Reset values: `core_key`=0, `core_start`=0, `busy`=0, `finish`=0, `found`=0, `secret_key`=0, `found_core_id`=0, `keys_tried`=0; state IDLE.
- First `core_start` pulse occurs 1 cycle after the `start` pulse.
- Peak throughput: one dispatch per cycle.
- A core must drop `core_done` in the cycle after its `core_start`. The dispatcher never samples a core's `core_done` earlier than 2 cycles after starting it. With NUM_CORES=1, the scan inserts one idle cycle after each start.
- `finish` and `found` rise together, 1 cycle after the deciding sample.
- Mid-search `reset` returns everything to reset values asynchronously. Cores are not pulsed.

## Configuration
- `RC4_CRACK_PROGRESS_EN` defined: `keys_tried` counter is implemented.
- Not defined: `keys_tried` is tied to 0 and the counter register is removed. All other behaviour is identical.

## Structure
- Package `rc4_crack_pkg` holds:
  - state enum `dispatch_state_t`;
  - default `KEY_W` = 24.
- One sub-module, `rc4_crack_slot`: holds the per-core `inflight` bit, `core_key` register and `core_start` pulse generation. It is instantiated NUM_CORES times via generate.

## Test plan
- NUM_CORES=4, range 0x000010–0x00001F, model core valid only for key 0x000017 (latency 20):
  - `found`=1, `secret_key`=0x000017, `found_core_id`=3 (0x17 is the 8th key dispatched, round-robin from core 0 → core (8−1) mod 4 = 3);
  - `keys_tried` ≤16.
- Range 0xFFFFF0–0xFFFFFF, no valid key:
  - DRAIN entered after 16 dispatches;
  - `finish`=1, `found`=0, `secret_key`=0xFFFFFF, `keys_tried`=16;
  - no wrap to 0.
- `key_lo`=5, `key_hi`=4: `finish`=1 one cycle after `start`, `found`=0, `keys_tried`=0, no `core_start`.
- Two cores valid in the same scan window (cores 1 and 2): `found_core_id`=1.
- `abort` raised 10 cycles into the search: DONE next cycle, `found`=0; a subsequent `start` restarts cleanly from the new `key_lo`.
- NUM_CORES=1, core latency 3: every `core_start` is separated by ≥2 cycles; range 0–7 completes with `keys_tried`=8.
